counter_driver: RTL and testbench

Sequencing controller for the 8-bit loadable down-counter (`latch` / `dec` / `divide_by_two` / `zero` interface). The block sits on the command side of that counter:
- accepts a countdown job over a valid/ready handshake;
- loads the counter, then issues decrement or halve commands until the counter reports zero;
- returns the number of commands issued, or an abort/timeout status, over a second handshake.

---
 rtl/counter_driver_pkg.sv | 24 ++
 rtl/counter_driver.sv | 117 +++++++++++
 tb/tb_counter_driver.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_driver_pkg
// Description : Shared types and constants for the countdown sequencing driver.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_driver_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 260;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_ABORTED = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/counter_driver.sv
`default_nettype none
// ============================================================================
// Module      : counter_driver
// Description : Loads a down-counter, issues dec/halve commands until it reads
//               zero, then reports the command count and completion status.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_value,
    input  logic             start_halve,
    input  logic             abort,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] done_steps,
    output logic [1:0]       done_status,
    output logic             cnt_latch,
    output logic [WIDTH-1:0] cnt_in,
    output logic             cnt_dec,
    output logic             cnt_divide_by_two,
    input  logic             cnt_zero
);

    localparam int                  c_timer_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WIDTH-1:0]       r_value;
    logic                   r_halve;
    logic [WIDTH-1:0]       r_steps;
    logic [c_timer_w-1:0]   r_timer;
    logic [1:0]             r_status;
    logic                   w_timeout;
    logic                   w_issue;

    // RUN priority: abort, then zero, then timeout; only otherwise is a command issued.
    assign w_timeout = (r_timer == c_timer_last);
    assign w_issue   = (r_state == ST_RUN) && !abort && !cnt_zero && !w_timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_value  <= '0;
            r_halve  <= 1'b0;
            r_steps  <= '0;
            r_timer  <= '0;
            r_status <= STATUS_OK;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_value  <= start_value;
                        r_halve  <= start_halve;
                        r_steps  <= '0;
                        r_timer  <= '0;
                        r_status <= STATUS_OK;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_status <= STATUS_ABORTED;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_status <= STATUS_ABORTED;
                    end else if (cnt_zero) begin
                        r_status <= STATUS_OK;
                    end else if (w_timeout) begin
                        r_status <= STATUS_TIMEOUT;
                    end else begin
                        if (r_steps != '1) begin
                            r_steps <= r_steps + WIDTH'(1);
                        end
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start_valid) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = abort ? ST_DONE : ST_RUN;
            ST_RUN:  if (abort || cnt_zero || w_timeout) w_next_state = ST_DONE;
            ST_DONE: if (done_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready       = (r_state == ST_IDLE);
        done_valid        = (r_state == ST_DONE);
        done_steps        = (r_state == ST_DONE) ? r_steps : '0;
        done_status       = (r_state == ST_DONE) ? r_status : STATUS_OK;
        cnt_latch         = (r_state == ST_LOAD) && !abort;
        cnt_in            = (r_state == ST_LOAD) ? r_value : '0;
        cnt_dec           = w_issue && !r_halve;
        cnt_divide_by_two = w_issue && r_halve;
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_driver
// Description : Directed bench for counter_driver driving a behavioural counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] start_value = 8'd0;
    logic       start_halve = 1'b0;
    logic       abort = 1'b0;
    logic       done_valid;
    logic       done_ready = 1'b0;
    logic [7:0] done_steps;
    logic [1:0] done_status;
    logic       cnt_latch;
    logic [7:0] cnt_in;
    logic       cnt_dec;
    logic       cnt_div;
    logic       cnt_zero;

    logic       t_start_valid = 1'b0;
    logic       t_start_ready;
    logic       t_done_valid;
    logic       t_done_ready = 1'b0;
    logic [7:0] t_done_steps;
    logic [1:0] t_done_status;
    logic       t_cnt_latch;
    logic [7:0] t_cnt_in;
    logic       t_cnt_dec;
    logic       t_cnt_div;
    logic       t_cnt_zero;

    logic [7:0] cval  = 8'd0;
    logic [7:0] t_cval = 8'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Behavioural model of the loadable down-counter each driver commands.
    always @(posedge clock) begin
        if (cnt_latch)    cval <= cnt_in;
        else if (cnt_dec) cval <= cval - 8'd1;
        else if (cnt_div) cval <= cval >> 1;
        if (t_cnt_latch)    t_cval <= t_cnt_in;
        else if (t_cnt_dec) t_cval <= t_cval - 8'd1;
        else if (t_cnt_div) t_cval <= t_cval >> 1;
    end
    assign cnt_zero   = (cval == 8'd0);
    assign t_cnt_zero = (t_cval == 8'd0);

    counter_driver #(.WIDTH(8), .TIMEOUT(260)) dut (
        .clock(clock), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_value(start_value), .start_halve(start_halve),
        .abort(abort),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_steps(done_steps), .done_status(done_status),
        .cnt_latch(cnt_latch), .cnt_in(cnt_in),
        .cnt_dec(cnt_dec), .cnt_divide_by_two(cnt_div),
        .cnt_zero(cnt_zero)
    );

    counter_driver #(.WIDTH(8), .TIMEOUT(4)) dut_to (
        .clock(clock), .reset(reset),
        .start_valid(t_start_valid), .start_ready(t_start_ready),
        .start_value(start_value), .start_halve(start_halve),
        .abort(1'b0),
        .done_valid(t_done_valid), .done_ready(t_done_ready),
        .done_steps(t_done_steps), .done_status(t_done_status),
        .cnt_latch(t_cnt_latch), .cnt_in(t_cnt_in),
        .cnt_dec(t_cnt_dec), .cnt_divide_by_two(t_cnt_div),
        .cnt_zero(t_cnt_zero)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one job with done_ready=1; cycle 0 is the handshake cycle.
    task automatic run_job(input logic [7:0] v, input logic h,
                           output int pulses, output int done_cyc);
        int viol;
        viol = 0;
        pulses = 0;
        done_cyc = -1;
        tick();
        start_valid = 1'b1;
        start_value = v;
        start_halve = h;
        done_ready  = 1'b1;
        settle();
        chk("job_start_ready", start_ready, 1);
        for (int c = 1; c <= 400; c++) begin
            tick();
            start_valid = 1'b0;
            settle();
            if (cnt_dec || cnt_div) pulses++;
            if ((cnt_dec && cnt_div) || ((cnt_dec || cnt_div) && cnt_latch) || (cnt_dec && cnt_zero))
                viol++;
            if (done_valid) begin
                done_cyc = c;
                break;
            end
        end
        chk("job_cmd_exclusive", viol, 0);
    endtask

    initial begin
        int pulses;
        int dcyc;
        int decs;

        // Reset state
        tick();
        tick();
        chk("rst_start_ready", start_ready, 1);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_cnt_latch", cnt_latch, 0);
        chk("rst_cnt_in", cnt_in, 0);
        chk("rst_cnt_cmds", {cnt_dec, cnt_div}, 0);
        chk("rst_done_steps", done_steps, 0);
        reset = 1'b0;

        // Decrement mode, V=5
        tick();
        start_valid = 1'b1; start_value = 8'd5; start_halve = 1'b0; done_ready = 1'b1;
        settle();
        chk("d5_ready_c0", start_ready, 1);
        tick();
        start_valid = 1'b0;
        settle();
        chk("d5_latch_c1", cnt_latch, 1);
        chk("d5_in_c1", cnt_in, 5);
        chk("d5_dec_c1", cnt_dec, 0);
        decs = 0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            settle();
            if (cnt_dec && !cnt_div && !cnt_latch) decs++;
        end
        chk("d5_dec_c2_6", decs, 5);
        tick();
        settle();
        chk("d5_dv_c7", done_valid, 0);
        chk("d5_dec_c7", cnt_dec, 0);
        chk("d5_in_c7", cnt_in, 0);
        tick();
        settle();
        chk("d5_dv_c8", done_valid, 1);
        chk("d5_steps", done_steps, 5);
        chk("d5_status", done_status, 0);
        chk("d5_zero", cnt_zero, 1);
        tick();
        settle();
        chk("d5_idle_c9", start_ready, 1);
        chk("d5_dv_c9", done_valid, 0);

        // Halve mode, V=200
        run_job(8'd200, 1'b1, pulses, dcyc);
        chk("h200_pulses", pulses, 8);
        chk("h200_steps", done_steps, 8);
        chk("h200_status", done_status, 0);
        chk("h200_done_cyc", dcyc, 11);
        chk("h200_zero", cnt_zero, 1);

        // Zero value, both modes
        run_job(8'd0, 1'b0, pulses, dcyc);
        chk("z_dec_pulses", pulses, 0);
        chk("z_dec_steps", done_steps, 0);
        chk("z_dec_status", done_status, 0);
        chk("z_dec_done_cyc", dcyc, 3);
        run_job(8'd0, 1'b1, pulses, dcyc);
        chk("z_hlv_pulses", pulses, 0);
        chk("z_hlv_done_cyc", dcyc, 3);

        // Reset during the 40th command of V=100, then a V=3 job
        tick();
        start_valid = 1'b1; start_value = 8'd100; start_halve = 1'b0; done_ready = 1'b1;
        settle();
        for (int c = 1; c <= 41; c++) begin
            tick();
            start_valid = 1'b0;
            settle();
        end
        chk("mr_dec_c41", cnt_dec, 1);
        reset = 1'b1;
        #1;
        chk("mr_start_ready", start_ready, 1);
        chk("mr_cnt_dec", cnt_dec, 0);
        chk("mr_done_valid", done_valid, 0);
        chk("mr_latch_in", {cnt_latch, cnt_in}, 0);
        tick();
        reset = 1'b0;
        run_job(8'd3, 1'b0, pulses, dcyc);
        chk("mr_v3_pulses", pulses, 3);
        chk("mr_v3_steps", done_steps, 3);
        chk("mr_v3_status", done_status, 0);
        chk("mr_v3_done_cyc", dcyc, 6);

        // V=255 with abort in the 10th RUN cycle, then held result
        tick();
        start_valid = 1'b1; start_value = 8'd255; start_halve = 1'b0; done_ready = 1'b0;
        settle();
        for (int c = 1; c <= 10; c++) begin
            tick();
            start_valid = 1'b0;
            settle();
        end
        tick();
        abort = 1'b1;
        settle();
        chk("ab_dec_c11", cnt_dec, 0);
        tick();
        abort = 1'b0;
        settle();
        chk("ab_dv_c12", done_valid, 1);
        chk("ab_steps", done_steps, 9);
        chk("ab_status", done_status, 1);
        chk("ab_counter", cval, 246);
        start_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            settle();
            chk("ab_hold_dv", done_valid, 1);
            chk("ab_hold_steps", done_steps, 9);
            chk("ab_hold_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        settle();
        chk("ab_hold_status", done_status, 1);
        tick();
        settle();
        chk("ab_idle_ready", start_ready, 1);
        chk("ab_idle_dv", done_valid, 0);
        chk("ab_idle_latch", cnt_latch, 0);

        // TIMEOUT=4 instance, V=20 decrement
        tick();
        t_start_valid = 1'b1; start_value = 8'd20; start_halve = 1'b0; t_done_ready = 1'b1;
        settle();
        pulses = 0;
        dcyc = -1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            t_start_valid = 1'b0;
            settle();
            if (t_cnt_dec || t_cnt_div) pulses++;
            if (t_done_valid) begin
                dcyc = c;
                break;
            end
        end
        chk("to_pulses", pulses, 3);
        chk("to_steps", t_done_steps, 3);
        chk("to_status", t_done_status, 2);
        chk("to_done_cyc", dcyc, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
